// File: rtl/alu_ctrl_seq_if.sv
// Decode request / result bundle between the ID stage and the registered ALU controller,
// including the handshake with the external iterative mul/div unit.
interface alu_ctrl_seq_if #(
  parameter int OP_W = 5
);
  logic            in_valid;
  logic            is_rtype;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            flush;
  logic            md_done;
  logic [OP_W-1:0] Operation;
  logic            op_valid;
  logic            illegal;
  logic            md_start;
  logic            stall;
  logic            md_err;

  modport master (
    output in_valid, is_rtype, ALUOp, Funct7, Funct3, flush, md_done,
    input  Operation, op_valid, illegal, md_start, stall, md_err
  );

  modport slave (
    input  in_valid, is_rtype, ALUOp, Funct7, Funct3, flush, md_done,
    output Operation, op_valid, illegal, md_start, stall, md_err
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ID/EX ALU controller; with ALU_MEXT_EN defined it also sequences RV32M ops
// through an external mul/div unit (IDLE/BUSY FSM with stall, flush abort and timeout).
module alu_ctrl_seq #(
  parameter int OP_W       = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam logic [4:0] C_AND     = 5'd0;
  localparam logic [4:0] C_OR      = 5'd1;
  localparam logic [4:0] C_ADD     = 5'd2;
  localparam logic [4:0] C_SUB     = 5'd3;
  localparam logic [4:0] C_SLL     = 5'd4;
  localparam logic [4:0] C_SRL     = 5'd5;
  localparam logic [4:0] C_SRA     = 5'd6;
  localparam logic [4:0] C_XOR     = 5'd7;
  localparam logic [4:0] C_SLT     = 5'd8;
  localparam logic [4:0] C_SLTU    = 5'd9;
  localparam logic [4:0] C_BEQ     = 5'd10;
  localparam logic [4:0] C_BNE     = 5'd11;
  localparam logic [4:0] C_BLT     = 5'd12;
  localparam logic [4:0] C_BGE     = 5'd13;
  localparam logic [4:0] C_BLTU    = 5'd14;
  localparam logic [4:0] C_BGEU    = 5'd15;
  localparam logic [4:0] C_PASSB   = 5'd16;
  localparam logic [4:0] C_HALT    = 5'd17;
  localparam logic [4:0] C_ILLEGAL = 5'd31;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  logic [4:0]      dec_code;
  logic            dec_illegal;
  logic            accept;
  logic [OP_W-1:0] operation_reg, operation_next;
  logic            op_valid_reg, op_valid_next;
  logic            illegal_reg, illegal_next;

  always_comb begin
    dec_code = C_ILLEGAL;
    case (bus.ALUOp)
      2'b00: dec_code = C_ADD;
      2'b11: dec_code = C_PASSB;
      2'b01: begin
        case (bus.Funct3)
          3'b000:  dec_code = C_BEQ;
          3'b001:  dec_code = C_BNE;
          3'b010:  dec_code = C_HALT;
          3'b100:  dec_code = C_BLT;
          3'b101:  dec_code = C_BGE;
          3'b110:  dec_code = C_BLTU;
          3'b111:  dec_code = C_BGEU;
          default: dec_code = C_ILLEGAL;
        endcase
      end
      default: begin
        if (bus.is_rtype && bus.Funct7 == F7_MEXT) begin
`ifdef ALU_MEXT_EN
          dec_code = 5'd18 + {2'b00, bus.Funct3};
`else
          dec_code = C_ILLEGAL;
`endif
        end else if (bus.is_rtype && bus.Funct7 != F7_BASE && bus.Funct7 != F7_ALT) begin
          dec_code = C_ILLEGAL;
        end else begin
          case (bus.Funct3)
            3'b000:  dec_code = (bus.is_rtype && bus.Funct7 == F7_ALT) ? C_SUB : C_ADD;
            3'b001:  dec_code = C_SLL;
            3'b010:  dec_code = C_SLT;
            3'b011:  dec_code = C_SLTU;
            3'b100:  dec_code = C_XOR;
            3'b101:  dec_code = (bus.Funct7 == F7_BASE) ? C_SRL :
                                (bus.Funct7 == F7_ALT)  ? C_SRA : C_ILLEGAL;
            3'b110:  dec_code = C_OR;
            default: dec_code = C_AND;
          endcase
        end
      end
    endcase
  end

  assign dec_illegal = (dec_code == C_ILLEGAL);

`ifdef ALU_MEXT_EN
  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic            md_start_reg, md_start_next;
  logic            md_err_reg, md_err_next;
  logic            stall_w;
  logic            dec_mext;

  assign dec_mext = (dec_code >= 5'd18) && (dec_code <= 5'd25);
  // The done cycle releases the stall, so a new instruction can be taken on that same edge.
  assign stall_w  = (state_reg == BUSY) && !bus.md_done;
  assign accept   = bus.in_valid && !bus.flush && !stall_w;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    md_start_next = 1'b0;
    md_err_next   = 1'b0;
    if (state_reg == BUSY) begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (bus.flush) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else if (bus.md_done) begin
        state_next = IDLE;
      end else if (cnt_reg == CNT_W'(MD_TIMEOUT - 1)) begin
        state_next  = IDLE;
        md_err_next = 1'b1;
      end
    end
    if (accept && dec_mext) begin
      state_next    = BUSY;
      cnt_next      = '0;
      md_start_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      md_start_reg <= 1'b0;
      md_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      md_start_reg <= md_start_next;
      md_err_reg   <= md_err_next;
    end
  end

  assign bus.stall    = stall_w;
  assign bus.md_start = md_start_reg;
  assign bus.md_err   = md_err_reg;
`else
  logic [CNT_W:0] unused_mext;

  assign unused_mext  = {bus.md_done, {CNT_W{1'b0}}};
  assign accept       = bus.in_valid && !bus.flush;
  assign bus.stall    = 1'b0;
  assign bus.md_start = 1'b0;
  assign bus.md_err   = 1'b0;
`endif

  always_comb begin
    op_valid_next  = accept;
    operation_next = operation_reg;
    illegal_next   = illegal_reg;
    if (accept) begin
      operation_next = OP_W'(dec_code);
      illegal_next   = dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operation_reg <= '0;
      op_valid_reg  <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      operation_reg <= operation_next;
      op_valid_reg  <= op_valid_next;
      illegal_reg   <= illegal_next;
    end
  end

  assign bus.Operation = operation_reg;
  assign bus.op_valid  = op_valid_reg;
  assign bus.illegal   = illegal_reg;

endmodule
